// File: rtl/ls_serial_pkg.sv
// ls_serial_pkg: shared definitions for the ls74194-style serial link.
// Used by the receiver (ls_serial_rx) and intended for the matching transmitter.
package ls_serial_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/ls_sipo_core.sv
// ls_sipo_core: WIDTH-bit serial-in parallel-out shift register.
// shift_right=1 enters sin at the MSB and moves bits toward q[0];
// shift_right=0 enters sin at the LSB and moves bits toward q[WIDTH-1],
// matching the two shift modes of the ls74194 used by the transmitter.
module ls_sipo_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             shift_en,
   input  logic             shift_right,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   // Shift one position per enabled edge in the selected direction.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q <= '0;
      end else if (shift_en) begin
         if (shift_right) begin
            q <= {sin, q[WIDTH-1:1]};
         end else begin
            q <= {q[WIDTH-2:0], sin};
         end
      end
   end

endmodule

// File: rtl/ls_serial_rx.sv
// ls_serial_rx: framed serial-to-parallel receiver.
// Frame: start(0), WIDTH data bits, [even parity bit], stop(1), one bit per bit_en.
// Optional parity checking and the parity_err port are enabled by defining
// LS_SERIAL_RX_PARITY_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit on a strobe
// DATA   | shifting in WIDTH data bits
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling the stop bit, then publishing or flagging the frame
module ls_serial_rx
   import ls_serial_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             bit_en,
   input  logic             sin,
   input  logic             lsb_first,
   output logic [WIDTH-1:0] q,
   output logic             valid,
   output logic             frame_err,
   output logic             busy
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
   ,
   output logic             parity_err
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   rx_state_t        state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             order, order_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             valid_nxt;
   logic             ferr_nxt;
   logic             shift_en;
   logic [WIDTH-1:0] shreg;
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
   logic             par_bad, par_bad_nxt;
   logic             perr_nxt;
`endif

   // Data shift register; direction follows the order flag latched at start.
   ls_sipo_core #(.WIDTH(WIDTH)) u_sipo (
      .clk         (clk),
      .clear_n     (clear_n),
      .shift_en    (shift_en),
      .shift_right (order),
      .sin         (sin),
      .q           (shreg)
   );

   // State, counter, order flag and registered outputs.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state     <= IDLE;
         cnt       <= '0;
         order     <= 1'b0;
         q         <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         order     <= order_nxt;
         q         <= q_nxt;
         valid     <= valid_nxt;
         frame_err <= ferr_nxt;
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
         par_bad    <= par_bad_nxt;
         parity_err <= perr_nxt;
`endif
      end
   end

   // Next-state and next-output decode; nothing advances without a strobe.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      order_nxt = order;
      q_nxt     = q;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      shift_en  = 1'b0;
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif
      if (bit_en) begin
         case (state)
            IDLE: begin
               if (sin == START_LEVEL) begin
                  state_nxt = DATA;
                  cnt_nxt   = '0;
                  order_nxt = lsb_first;
               end
            end
            DATA: begin
               shift_en = 1'b1;
               if (cnt == LAST_BIT) begin
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
            PARITY: begin
               // All data bits are in shreg by now; even parity means XOR is 0.
               par_bad_nxt = (^shreg) ^ sin;
               state_nxt   = STOP;
            end
`endif
            STOP: begin
               state_nxt = IDLE;
               if (sin == STOP_LEVEL) begin
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
                  if (par_bad) begin
                     perr_nxt = 1'b1;
                  end else begin
                     q_nxt     = shreg;
                     valid_nxt = 1'b1;
                  end
`else
                  q_nxt     = shreg;
                  valid_nxt = 1'b1;
`endif
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ls_serial_rx.sv
// tb_ls_serial_rx: directed-frame bench for ls_serial_rx with a frame-level
// reference model and per-cycle output comparison.
// Define LS_SERIAL_RX_PARITY_CHECK_EN to exercise the parity build.
`timescale 1ns/1ps
module tb_ls_serial_rx;

   localparam int WIDTH = 4;
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int STOP_IDX = WIDTH + 1 + PAR;

   logic             clk = 1'b0;
   logic             clear_n = 1'b0;
   logic             bit_en = 1'b0;
   logic             sin = 1'b1;
   logic             lsb_first = 1'b0;
   logic [WIDTH-1:0] q;
   logic             valid, frame_err, busy;
   logic             perr_dut;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;

   always #5 clk = ~clk;

   ls_serial_rx #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .bit_en     (bit_en),
      .sin        (sin),
      .lsb_first  (lsb_first),
      .q          (q),
      .valid      (valid),
      .frame_err  (frame_err),
      .busy       (busy)
`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
      ,
      .parity_err (perr_dut)
`endif
   );
`ifndef LS_SERIAL_RX_PARITY_CHECK_EN
   assign perr_dut = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collect the strobed bits of a frame, then place data bit i
   // at position i (lsb first) or WIDTH-1-i (msb first).
   function automatic logic [WIDTH-1:0] frame_word(input logic [WIDTH-1:0] bits, input logic ord);
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ord) w[i] = bits[i];
         else     w[WIDTH-1-i] = bits[i];
      end
      return w;
   endfunction

   int               m_n;
   logic [WIDTH-1:0] m_data;
   logic             m_ord, m_par;
   logic [WIDTH-1:0] exp_q;
   logic             exp_valid, exp_ferr, exp_perr;

   // Model update on every edge.
   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         m_n <= 0; m_data <= '0; m_ord <= 1'b0; m_par <= 1'b0;
         exp_q <= '0; exp_valid <= 1'b0; exp_ferr <= 1'b0; exp_perr <= 1'b0;
      end else begin
         exp_valid <= 1'b0; exp_ferr <= 1'b0; exp_perr <= 1'b0;
         if (bit_en) begin
            if (m_n == 0) begin
               if (sin == 1'b0) begin
                  m_n   <= 1;
                  m_ord <= lsb_first;
               end
            end else if (m_n <= WIDTH) begin
               m_data[m_n-1] <= sin;
               m_n <= m_n + 1;
            end else if (m_n < STOP_IDX) begin
               m_par <= sin;
               m_n <= m_n + 1;
            end else begin
               m_n <= 0;
               if (sin == 1'b0) begin
                  exp_ferr <= 1'b1;
               end else if (PAR == 1 && ((^m_data) ^ m_par) == 1'b1) begin
                  exp_perr <= 1'b1;
               end else begin
                  exp_q     <= frame_word(m_data, m_ord);
                  exp_valid <= 1'b1;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus pulse counting.
   always @(negedge clk) begin
      if (clear_n) begin
         check("q", 32'(q), 32'(exp_q));
         check("valid", 32'(valid), 32'(exp_valid));
         check("frame_err", 32'(frame_err), 32'(exp_ferr));
         check("busy", 32'(busy), 32'(m_n != 0));
         check("parity_err", 32'(perr_dut), 32'(exp_perr));
         if (valid) valid_cnt++;
         if (frame_err) ferr_cnt++;
         if (perr_dut) perr_cnt++;
      end
   end

   task automatic strobe(input logic b, input int gap);
      @(negedge clk);
      bit_en = 1'b1;
      sin    = b;
      repeat (gap - 1) begin
         @(negedge clk);
         bit_en = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bit_en = 1'b0;
         sin    = 1'b1;
      end
   endtask

   // data_tx is listed in transmission order: data_tx[WIDTH-1] goes first.
   task automatic send_frame(input logic [WIDTH-1:0] data_tx, input logic stop_b,
                             input logic lsb, input int gap, input int toggle_at,
                             input logic bad_par);
      lsb_first = lsb;
      strobe(1'b0, gap);
      for (int i = 0; i < WIDTH; i++) begin
         if (i == toggle_at) lsb_first = ~lsb_first;
         strobe(data_tx[WIDTH-1-i], gap);
      end
      if (PAR == 1) strobe((^data_tx) ^ bad_par, gap);
      strobe(stop_b, gap);
   endtask

   int v0, f0, p0;

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      clear_n = 1'b1;
      @(negedge clk); #1;
      check("rst_q", 32'(q), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_ferr", 32'(frame_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);

      // lsb first: sin 0,0,1,0,1,1 -> 1010
      v0 = valid_cnt;
      send_frame(4'b0101, 1'b1, 1'b1, 1, -1, 1'b0);
      idle(3);
      check("lsb_q", 32'(q), 32'hA);
      check("lsb_pulses", 32'(valid_cnt - v0), 32'd1);
      check("lsb_busy", 32'(busy), 32'h0);

      // msb first: sin 0,1,0,1,1,1 -> 1011
      v0 = valid_cnt;
      send_frame(4'b1011, 1'b1, 1'b0, 1, -1, 1'b0);
      idle(2);
      check("msb_q", 32'(q), 32'hB);
      check("msb_pulses", 32'(valid_cnt - v0), 32'd1);

      // same frame, strobe every 3rd cycle
      v0 = valid_cnt;
      send_frame(4'b1011, 1'b1, 1'b0, 3, -1, 1'b0);
      idle(2);
      check("slow_q", 32'(q), 32'hB);
      check("slow_pulses", 32'(valid_cnt - v0), 32'd1);

      // bad stop: 0,1,1,1,1,0 -> frame_err, q holds 1011
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(4'b1111, 1'b0, 1'b0, 1, -1, 1'b0);
      idle(2);
      check("ferr_q", 32'(q), 32'hB);
      check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
      check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);

      // bad stop then back-to-back good frame 0110
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(4'b1111, 1'b0, 1'b0, 1, -1, 1'b0);
      send_frame(4'b0110, 1'b1, 1'b0, 1, -1, 1'b0);
      idle(2);
      check("b2b_q", 32'(q), 32'h6);
      check("b2b_ferr", 32'(ferr_cnt - f0), 32'd1);
      check("b2b_valid", 32'(valid_cnt - v0), 32'd1);

      // lsb_first toggled after two data bits: latched lsb order -> 0011
      send_frame(4'b1100, 1'b1, 1'b1, 1, 2, 1'b0);
      idle(2);
      check("toggle_q", 32'(q), 32'h3);

      // reset after the 2nd data bit
      v0 = valid_cnt;
      lsb_first = 1'b1;
      strobe(1'b0, 1);
      strobe(1'b1, 1);
      strobe(1'b0, 1);
      @(negedge clk);
      bit_en  = 1'b0;
      clear_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_valid", 32'(valid), 32'h0);
      check("midrst_q", 32'(q), 32'h0);
      @(negedge clk);
      clear_n = 1'b1;
      idle(2);
      check("midrst_no_pulse", 32'(valid_cnt - v0), 32'd0);
      send_frame(4'b1001, 1'b1, 1'b1, 1, -1, 1'b0);
      idle(2);
      check("midrst_next_q", 32'(q), 32'h9);
      check("midrst_next_pulse", 32'(valid_cnt - v0), 32'd1);

`ifdef LS_SERIAL_RX_PARITY_CHECK_EN
      // data 1011, parity 1, stop 1 -> valid
      v0 = valid_cnt; p0 = perr_cnt;
      send_frame(4'b1011, 1'b1, 1'b0, 1, -1, 1'b0);
      idle(2);
      check("par_good_q", 32'(q), 32'hB);
      check("par_good_valid", 32'(valid_cnt - v0), 32'd1);
      check("par_good_noerr", 32'(perr_cnt - p0), 32'd0);

      // data 0110 with wrong parity -> parity_err, q holds 1011
      v0 = valid_cnt; p0 = perr_cnt;
      send_frame(4'b0110, 1'b1, 1'b0, 1, -1, 1'b1);
      idle(2);
      check("par_bad_q", 32'(q), 32'hB);
      check("par_bad_perr", 32'(perr_cnt - p0), 32'd1);
      check("par_bad_novalid", 32'(valid_cnt - v0), 32'd0);

      // bad parity and bad stop -> frame_err only
      f0 = ferr_cnt; p0 = perr_cnt;
      send_frame(4'b0110, 1'b0, 1'b0, 1, -1, 1'b1);
      idle(2);
      check("par_ferr", 32'(ferr_cnt - f0), 32'd1);
      check("par_ferr_noperr", 32'(perr_cnt - p0), 32'd0);
`else
      p0 = perr_cnt;
      check("no_parity_pulses", 32'(p0), 32'd0);
`endif

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ls_serial_rx.md
Name: ls_serial_rx

Overview:
- Framed serial-to-parallel receiver.
- It is the receiving end of the serial link whose transmitter is the ls74194-based shift register, shifted out one bit per strobe.
- Detects a start bit, shifts in WIDTH data bits in a selectable order, checks the stop bit, and presents the assembled word with a one-cycle valid pulse.
- Sits between the serial link pin/strobe logic and the CPU register file load path.

Parameters:
- WIDTH, 4, data bits per frame; legal range is 2 to 16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear_n  input  1  asynchronous active-low reset.
- bit_en  input  1  bit strobe; the line is sampled only on clock edges where bit_en=1.
- sin  input  1  serial line; idles high.
- lsb_first  input  1  1 = first data bit is q[0]; 0 = first data bit is q[WIDTH-1].
- q  output  WIDTH  last good received word.
- valid  output  1  one-cycle pulse: q was updated with a good frame.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high from start-bit detect until the stop-bit sample.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - q=0, valid=0, frame_err=0, busy=0.
  - State=IDLE, bit counter=0, shift register=0.
  - Reset mid-frame abandons the frame immediately; no pulse is generated.
- Edges with bit_en=0: state, counter, shift register and q hold. valid/frame_err return to 0.
- Frame format: start bit (0), then WIDTH data bits, then [parity bit if PARITY_CHECK_EN], then stop bit (1).
- IDLE:
  - bit_en=1 and sin=0: go to DATA, counter=0, busy=1, latch lsb_first into an internal order flag.
  - The order flag is held for the whole frame, so lsb_first changes mid-frame are ignored.
  - sin=1: stay in IDLE.
- DATA, per bit_en:
  - Order flag=1: shreg <= {sin, shreg[WIDTH-1:1]}.
  - Order flag=0: shreg <= {shreg[WIDTH-2:0], sin}.
  - counter increments. When counter==WIDTH-1 on this strobe, go to PARITY (feature on) or STOP.
- STOP, per bit_en:
  - sin=1: q<=shreg and valid=1 for exactly one cycle.
  - sin=0: frame_err=1 for one cycle; q unchanged.
  - Either way, busy=0 and go to IDLE.
- Latency: valid/frame_err are registered and assert in the cycle after the edge that samples the stop bit.
- Back-to-back frames: a start bit on the very next bit_en after the stop bit is accepted; no idle bit is required.
- Counter width is $clog2(WIDTH); it never wraps inside a frame.
- valid and frame_err are never high together.

Optional Feature:
- Macro: LS_SERIAL_RX_PARITY_CHECK_EN.
- Defined:
  - Adds a PARITY state after DATA; one bit_en sample there.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - Adds output parity_err (1 bit, reset 0).
  - On a good stop with bad parity: parity_err pulses one cycle, valid stays 0, q unchanged.
  - A bad stop bit gives frame_err only, regardless of parity.
- Undefined: no PARITY state and no parity_err port; the frame is start + WIDTH + stop.

Decomposition:
- Package ls_serial_pkg:
  - State enum {IDLE, DATA, PARITY, STOP}.
  - Constants START_LEVEL=1'b0, STOP_LEVEL=1'b1, IDLE_LEVEL=1'b1.
  - Shared with the future transmitter.
- One sub-module, ls_sipo_core: WIDTH-bit shift register with an enable and a direction select.
  - Mirrors the ls74194 shift-left/shift-right modes, so the receiver datapath stays symmetric with the transmitter.
- The FSM and counter live in ls_serial_rx.

Test Plan:
- Reset with clear_n=0, then release → q=0000, valid=0, frame_err=0, busy=0. Asserting clear_n=0 after the 2nd data bit of a frame → busy=0 at once, no valid pulse, next frame receives correctly.
- lsb_first=1, bit_en every cycle, sin=0,0,1,0,1,1 → q=1010, valid high for one cycle after the stop edge, busy low.
- lsb_first=0, sin=0,1,0,1,1,1 → q=1011 with a valid pulse. Same data with bit_en=1 only every 3rd cycle → same q, one valid pulse, state frozen between strobes.
- Frame 0,1,1,1,1,0 (bad stop) after a good 1011 → frame_err pulses once, valid=0, q stays 1011. A back-to-back frame starting on the next strobe → accepted.
- Toggle lsb_first mid-frame → word assembled in the order latched at start.
- With LS_SERIAL_RX_PARITY_CHECK_EN, lsb_first=0:
  - Data 1011 with parity bit 1, stop 1 → valid, q=1011.
  - Parity bit 0 → parity_err pulse, valid=0, q unchanged.
